// File: rtl/button_conditioner.sv
// button_conditioner: front-end input stage for the UI controller.
// Synchronises and debounces five pushbuttons and eight switches, then issues
// mutually exclusive one-cycle press pulses (enter > up > down > left > right).
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat on up/down while held).
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 2700000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter_raw,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic [7:0] switch_raw,
  output logic       enter,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [4:0] held,
  output logic [7:0] switches,
  output logic       switch_changed
);

  // Input vector order: {enter, up, down, left, right, switch[7:0]}
  localparam int unsigned NumIn = 13;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) || DEBOUNCE_CYCLES == 0 ||
      REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
    $error("button_conditioner: invalid parameter set");
  end

  logic [NumIn-1:0] w_raw;
  logic [NumIn-1:0] r_sync1, r_sync2;
  logic [NumIn-1:0] r_stable, r_stable_d;
  logic [NumIn-1:0] w_flip, w_stable_nxt;
  logic [CNT_W-1:0] r_cnt [NumIn];
  logic [4:0]       w_rise, w_inject, w_cand, w_win;
  logic [4:0]       r_pulse, r_pending;

  // Polarity flip is a constant inverter, so all sync flops reset to 0 = released.
  assign w_raw = {btn_enter_raw, btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
                  switch_raw} ^ {{5{ACTIVE_LOW}}, 8'h00};

  // Two-flop synchroniser for every input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable value flips once the synced input has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NumIn; i++) begin
      w_flip[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CntMax);
    end
  end

  assign w_stable_nxt = r_stable ^ w_flip;

  // Per-input debounce counters and stable values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumIn; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable   <= '0;
      r_stable_d <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (r_sync2[i] == r_stable[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_stable   <= w_stable_nxt;
      r_stable_d <= r_stable;
    end
  end

  assign w_rise = r_stable[12:8] & ~r_stable_d[12:8];

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW  = $clog2(RptMax + 1);

  typedef enum logic [1:0] {StIdle, StHoldWait, StRepeat} rpt_state_e;

  // Index 0 = down (button bit 2), index 1 = up (button bit 3).
  rpt_state_e       r_rpt_state [2];
  logic [HoldW-1:0] r_hold_cnt  [2];
  logic [1:0]       r_inject;

  // Hold/repeat FSM for up and down; release is taken from the next stable value so
  // no repeat fires on the cycle the button is seen released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        r_rpt_state[b] <= StIdle;
        r_hold_cnt[b]  <= '0;
      end
      r_inject <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_inject[b] <= 1'b0;
        unique case (r_rpt_state[b])
          StIdle: begin
            if (w_rise[2+b]) begin
              r_rpt_state[b] <= StHoldWait;
              r_hold_cnt[b]  <= HoldW'(1);
            end
          end
          StHoldWait: begin
            if (!w_stable_nxt[10+b]) begin
              r_rpt_state[b] <= StIdle;
              r_hold_cnt[b]  <= '0;
            end else if (r_hold_cnt[b] == HoldW'(REPEAT_DELAY - 1)) begin
              r_rpt_state[b] <= StRepeat;
              r_hold_cnt[b]  <= '0;
              r_inject[b]    <= 1'b1;
            end else begin
              r_hold_cnt[b] <= r_hold_cnt[b] + HoldW'(1);
            end
          end
          StRepeat: begin
            if (!w_stable_nxt[10+b]) begin
              r_rpt_state[b] <= StIdle;
              r_hold_cnt[b]  <= '0;
            end else if (r_hold_cnt[b] == HoldW'(REPEAT_PERIOD - 1)) begin
              r_hold_cnt[b] <= '0;
              r_inject[b]   <= 1'b1;
            end else begin
              r_hold_cnt[b] <= r_hold_cnt[b] + HoldW'(1);
            end
          end
          default: begin
            r_rpt_state[b] <= StIdle;
            r_hold_cnt[b]  <= '0;
          end
        endcase
      end
    end
  end

  assign w_inject = {1'b0, r_inject, 2'b00};
`else
  assign w_inject = '0;
`endif

  // Highest set bit wins; enter is bit 4.
  always_comb begin
    w_cand = r_pending | w_rise | w_inject;
    w_win  = '0;
    for (int i = 0; i < 5; i++) begin
      if (w_cand[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
      end
    end
  end

  // Registered pulse for the winner; losers wait in pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse   <= '0;
      r_pending <= '0;
    end else begin
      r_pulse   <= w_win;
      r_pending <= w_cand & ~w_win;
    end
  end

  assign {enter, up, down, left, right} = r_pulse;
  assign held           = r_stable[12:8];
  assign switches       = r_stable[7:0];
  assign switch_changed = (r_stable[7:0] != r_stable_d[7:0]);

endmodule
